// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set path.
// Time words pack six BCD digits as {H2,H1,M2,M1,S2,S1}.
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } rtc_set_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] HR_MAX  = 7'd23;
    localparam logic [6:0] MIN_MAX = 7'd59;

    // Digit positions inside TIME_IN/LOAD_VAL (nibble index) and BLANK_MASK (bit index)
    localparam int unsigned DIG_S1 = 0;
    localparam int unsigned DIG_S2 = 1;
    localparam int unsigned DIG_M1 = 2;
    localparam int unsigned DIG_M2 = 3;
    localparam int unsigned DIG_H1 = 4;
    localparam int unsigned DIG_H2 = 5;

    function automatic logic bcd_digit_valid(input bcd_digit_t d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/rtc_set_ctrl_if.sv
// Button, time and control bundle between the set controller and its neighbours.
interface rtc_set_ctrl_if;
    logic        BTN_MODE;
    logic        BTN_INC;
    logic [23:0] TIME_IN;
    logic        HOLD;
    logic        LOAD;
    logic [23:0] LOAD_VAL;
    logic [5:0]  BLANK_MASK;
    logic [1:0]  STATE;

    modport master (
        output BTN_MODE, BTN_INC, TIME_IN,
        input  HOLD, LOAD, LOAD_VAL, BLANK_MASK, STATE
    );

    modport slave (
        input  BTN_MODE, BTN_INC, TIME_IN,
        output HOLD, LOAD, LOAD_VAL, BLANK_MASK, STATE
    );
endinterface

// File: rtl/rtc_set_ctrl_bcd2_inc.sv
// Two-digit BCD increment with wrap to 00 above MAX.
// Any non-BCD digit also collapses the field to 00.
module bcd2_inc
    import rtc_pkg::*;
#(
    parameter logic [6:0] MAX = 7'd59
) (
    input  bcd_digit_t cur_tens,
    input  bcd_digit_t cur_units,
    output bcd_digit_t nxt_tens,
    output bcd_digit_t nxt_units
);

    logic [7:0] value_s;
    logic       wrap_s;

    assign value_s = ({4'd0, cur_tens} * 8'd10) + {4'd0, cur_units};
    assign wrap_s  = !bcd_digit_valid(cur_tens) || !bcd_digit_valid(cur_units) ||
                     (value_s >= {1'b0, MAX});

    // Next field value with units-to-tens carry
    always_comb begin
        nxt_tens  = 4'd0;
        nxt_units = 4'd0;
        if (wrap_s) begin
            nxt_tens  = 4'd0;
            nxt_units = 4'd0;
        end else if (cur_units == 4'd9) begin
            nxt_tens  = cur_tens + 4'd1;
            nxt_units = 4'd0;
        end else begin
            nxt_tens  = cur_tens;
            nxt_units = cur_units + 4'd1;
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-set sequencer: freezes the counters, edits hours then minutes in a
// shadow copy, and commits it with a single LOAD strobe.
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic          CLK1Hz,
    input  logic          RST,
    rtc_set_ctrl_if.slave bus
);

    localparam int unsigned    IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    rtc_set_state_t    state_r, state_nxt_s;
    logic [23:0]       shadow_r, shadow_nxt_s;
    logic [IDLE_W-1:0] idle_r, idle_nxt_s;
    logic              blink_r, blink_nxt_s;
    logic              mode_q_r, inc_q_r;
    logic              hold_r, hold_nxt_s;
    logic              load_r, load_nxt_s;
    logic [5:0]        mask_r, mask_nxt_s;
    logic              mode_e_s, inc_e_s;
    bcd_digit_t        hr_tens_s, hr_units_s, min_tens_s, min_units_s;

    assign mode_e_s = bus.BTN_MODE & ~mode_q_r;
    assign inc_e_s  = bus.BTN_INC & ~inc_q_r & ~mode_e_s;

    bcd2_inc #(.MAX(HR_MAX)) u_hr_inc (
        .cur_tens  (shadow_r[4*DIG_H2 +: 4]),
        .cur_units (shadow_r[4*DIG_H1 +: 4]),
        .nxt_tens  (hr_tens_s),
        .nxt_units (hr_units_s)
    );

    bcd2_inc #(.MAX(MIN_MAX)) u_min_inc (
        .cur_tens  (shadow_r[4*DIG_M2 +: 4]),
        .cur_units (shadow_r[4*DIG_M1 +: 4]),
        .nxt_tens  (min_tens_s),
        .nxt_units (min_units_s)
    );

    // Next state, shadow edits and idle timeout
    always_comb begin
        state_nxt_s  = state_r;
        shadow_nxt_s = shadow_r;
        idle_nxt_s   = idle_r;
        case (state_r)
            RUN: begin
                idle_nxt_s = '0;
                if (mode_e_s) begin
                    shadow_nxt_s = bus.TIME_IN;
                    state_nxt_s  = SET_HR;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            SET_HR, SET_MIN: begin
                if (mode_e_s) begin
                    idle_nxt_s = '0;
                    if (state_r == SET_MIN) begin
                        shadow_nxt_s[4*DIG_S1 +: 8] = 8'h00;
                        state_nxt_s = COMMIT;
                    end else begin
                        state_nxt_s = SET_MIN;
                    end
                end else if (idle_r == IDLE_LAST) begin
                    idle_nxt_s  = '0;
                    state_nxt_s = RUN;
                end else if (inc_e_s) begin
                    idle_nxt_s = '0;
                    if (state_r == SET_HR) begin
                        shadow_nxt_s[4*DIG_H1 +: 8] = {hr_tens_s, hr_units_s};
                    end else begin
                        shadow_nxt_s[4*DIG_M1 +: 8] = {min_tens_s, min_units_s};
                    end
                end else begin
                    idle_nxt_s = idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
                end
            end
            COMMIT: begin
                idle_nxt_s  = '0;
                state_nxt_s = RUN;
            end
            default: begin
                idle_nxt_s  = '0;
                state_nxt_s = RUN;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        blink_nxt_s = 1'b0;
        mask_nxt_s  = 6'd0;
        hold_nxt_s  = (state_nxt_s != RUN);
        load_nxt_s  = (state_nxt_s == COMMIT);
        if ((state_nxt_s == SET_HR) || (state_nxt_s == SET_MIN)) begin
            blink_nxt_s = ~blink_r;
        end else begin
            blink_nxt_s = 1'b0;
        end
        case (state_nxt_s)
            SET_HR: begin
                mask_nxt_s[DIG_H2] = blink_nxt_s;
                mask_nxt_s[DIG_H1] = blink_nxt_s;
            end
            SET_MIN: begin
                mask_nxt_s[DIG_M2] = blink_nxt_s;
                mask_nxt_s[DIG_M1] = blink_nxt_s;
            end
            default: begin
                mask_nxt_s = 6'd0;
            end
        endcase
    end

    // State, shadow and output registers
    always_ff @(posedge CLK1Hz) begin
        if (RST) begin
            state_r  <= RUN;
            shadow_r <= 24'd0;
            idle_r   <= '0;
            blink_r  <= 1'b0;
            mode_q_r <= 1'b1;
            inc_q_r  <= 1'b1;
            hold_r   <= 1'b0;
            load_r   <= 1'b0;
            mask_r   <= 6'd0;
        end else begin
            state_r  <= state_nxt_s;
            shadow_r <= shadow_nxt_s;
            idle_r   <= idle_nxt_s;
            blink_r  <= blink_nxt_s;
            mode_q_r <= bus.BTN_MODE;
            inc_q_r  <= bus.BTN_INC;
            hold_r   <= hold_nxt_s;
            load_r   <= load_nxt_s;
            mask_r   <= mask_nxt_s;
        end
    end

    assign bus.STATE      = state_r;
    assign bus.HOLD       = hold_r;
    assign bus.LOAD       = load_r;
    assign bus.LOAD_VAL   = shadow_r;
    assign bus.BLANK_MASK = mask_r;

endmodule
